// File: rtl/pulse_mode_pkg.sv
// Shared FSM state type, streak width and parameter sanity check for pulse_mode_classifier.
package pulse_mode_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEASURE  = 2'd1,
      CLASSIFY = 2'd2,
      STUCK    = 2'd3
   } ch_state_t;

   localparam int STREAK_W = 4;

   // The width counter must hold MAX_WIDTH, and the glitch/threshold/stuck limits must be ordered.
   function automatic bit widths_ok(input int cnt_w, input int min_w, input int thresh, input int max_w);
      return (longint'(max_w) < (longint'(1) << cnt_w)) && (min_w < thresh) && (thresh <= max_w);
   endfunction

endpackage

// File: rtl/pulse_mode_channel.sv
// One channel: input synchroniser, pulse-width FSM, classification streak and committed mode.
// Optional no-edge timeout is built when PULSE_LOSS_DETECT_EN is defined.
module pulse_mode_channel
   import pulse_mode_pkg::*;
#(
   parameter int CNT_W     = 18,
   parameter int THRESH    = 75000,
   parameter int MIN_WIDTH = 500,
   parameter int MAX_WIDTH = 200000,
   parameter int CONFIRM   = 5
`ifdef PULSE_LOSS_DETECT_EN
   ,
   parameter int LOSS_CYCLES = 2000000
`endif
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic             aux_in,
   output logic             mode_out,
   output logic             mode_valid,
   output logic             mode_change,
   output logic [CNT_W-1:0] last_width,
   output ch_state_t        state
);

   localparam logic [CNT_W-1:0]    CNT_SAT = '1;
   localparam logic [CNT_W-1:0]    MAX_CNT = CNT_W'(MAX_WIDTH);
   localparam logic [CNT_W-1:0]    MIN_CNT = CNT_W'(MIN_WIDTH);
   localparam logic [CNT_W-1:0]    TH_CNT  = CNT_W'(THRESH);
   localparam logic [STREAK_W-1:0] CONF    = STREAK_W'(CONFIRM);

   logic                sync1, sync2, sync3;
   logic [1:0]          warm;
   logic                armed;
   logic                rise, fall;
   logic [CNT_W-1:0]    cnt;
   logic [STREAK_W-1:0] streak;
   logic                last_class;
   logic                cls;
   logic [STREAK_W-1:0] streak_nx;
   logic                loss_hit;

   // A level already high when reset releases must not count as a rise: arm only after a
   // genuinely synchronised low has been seen.
   assign rise = sync2 & ~sync3 & armed;
   assign fall = ~sync2 & sync3;

   always_comb begin
      cls = (cnt >= TH_CNT);
      streak_nx = STREAK_W'(1);
      if (cls == last_class)
         streak_nx = (streak >= CONF) ? CONF : streak + STREAK_W'(1);
   end

`ifdef PULSE_LOSS_DETECT_EN
   localparam int              LOSS_W   = $clog2(LOSS_CYCLES + 1);
   localparam logic [LOSS_W-1:0] LOSS_END = LOSS_W'(LOSS_CYCLES);

   logic [LOSS_W-1:0] idle_cnt;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N)
         idle_cnt <= '0;
      else if (rise)
         idle_cnt <= '0;
      else if (idle_cnt != LOSS_END)
         idle_cnt <= idle_cnt + LOSS_W'(1);
   end

   assign loss_hit = !rise && (idle_cnt == LOSS_END - LOSS_W'(1));
`else
   assign loss_hit = 1'b0;
`endif

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         sync3       <= 1'b0;
         warm        <= '0;
         armed       <= 1'b0;
         state       <= IDLE;
         cnt         <= '0;
         streak      <= '0;
         last_class  <= 1'b0;
         mode_out    <= 1'b0;
         mode_valid  <= 1'b0;
         mode_change <= 1'b0;
         last_width  <= '0;
      end else begin
         sync1       <= aux_in;
         sync2       <= sync1;
         sync3       <= sync2;
         warm        <= {warm[0], 1'b1};
         mode_change <= 1'b0;
         if (warm[1] && !sync2)
            armed <= 1'b1;

         unique case (state)
            IDLE: begin
               if (rise) begin
                  state <= MEASURE;
                  cnt   <= CNT_W'(1);
               end
            end
            MEASURE: begin
               if (fall) begin
                  state <= CLASSIFY;
               end else begin
                  if (cnt != CNT_SAT)
                     cnt <= cnt + CNT_W'(1);
                  // Still high with MAX_WIDTH already counted: the high time now exceeds the limit.
                  if (cnt >= MAX_CNT)
                     state <= STUCK;
               end
            end
            CLASSIFY: begin
               if (cnt >= MIN_CNT) begin
                  last_width <= cnt;
                  streak     <= streak_nx;
                  last_class <= cls;
                  if (streak_nx == CONF && (!mode_valid || mode_out != cls)) begin
                     mode_out    <= cls;
                     mode_valid  <= 1'b1;
                     mode_change <= 1'b1;
                  end
               end
               if (rise) begin
                  state <= MEASURE;
                  cnt   <= CNT_W'(1);
               end else begin
                  state <= IDLE;
               end
            end
            STUCK: begin
               streak <= '0;
               if (fall)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (loss_hit) begin
            streak      <= '0;
            mode_valid  <= 1'b0;
            mode_change <= mode_valid;
         end
      end
   end

endmodule

// File: rtl/pulse_mode_classifier.sv
// Multi-channel pulse-width mode classifier: NUM_CH independent channels, LAST_WIDTH packed ch0 in LSBs.
// Define PULSE_LOSS_DETECT_EN to drop MODE_VALID after LOSS_CYCLES without a rising edge.
module pulse_mode_classifier
   import pulse_mode_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 18,
   parameter int THRESH      = 75000,
   parameter int MIN_WIDTH   = 500,
   parameter int MAX_WIDTH   = 200000,
   parameter int CONFIRM     = 5,
   parameter int LOSS_CYCLES = 2000000
) (
   input  logic                    CLOCK_50,
   input  logic                    RESET_N,
   input  logic [NUM_CH-1:0]       AUX_INPUT,
   output logic [NUM_CH-1:0]       MODE_OUT,
   output logic [NUM_CH-1:0]       MODE_VALID,
   output logic [NUM_CH-1:0]       MODE_CHANGE,
   output logic [NUM_CH-1:0]       STUCK_ERR,
   output logic [NUM_CH*CNT_W-1:0] LAST_WIDTH
);

   if (!widths_ok(CNT_W, MIN_WIDTH, THRESH, MAX_WIDTH)) begin : g_bad_widths
      $error("pulse_mode_classifier: need MAX_WIDTH < 2**CNT_W and MIN_WIDTH < THRESH <= MAX_WIDTH");
   end

   if (CONFIRM < 1 || CONFIRM > (1 << STREAK_W) - 1 || LOSS_CYCLES < 1) begin : g_bad_confirm
      $error("pulse_mode_classifier: CONFIRM must be 1..15 and LOSS_CYCLES positive");
   end

   ch_state_t ch_state [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pulse_mode_channel #(
         .CNT_W      (CNT_W),
         .THRESH     (THRESH),
         .MIN_WIDTH  (MIN_WIDTH),
         .MAX_WIDTH  (MAX_WIDTH),
         .CONFIRM    (CONFIRM)
`ifdef PULSE_LOSS_DETECT_EN
         ,
         .LOSS_CYCLES(LOSS_CYCLES)
`endif
      ) u_ch (
         .CLOCK_50   (CLOCK_50),
         .RESET_N    (RESET_N),
         .aux_in     (AUX_INPUT[i]),
         .mode_out   (MODE_OUT[i]),
         .mode_valid (MODE_VALID[i]),
         .mode_change(MODE_CHANGE[i]),
         .last_width (LAST_WIDTH[i*CNT_W +: CNT_W]),
         .state      (ch_state[i])
      );

      // STUCK_ERR is exactly the registered STUCK state.
      assign STUCK_ERR[i] = (ch_state[i] == STUCK);
   end

endmodule

// File: tb/tb_pulse_mode_classifier.sv
// Self-checking bench for pulse_mode_classifier: vector table, hand sequences and a pulse-level model.
module tb_pulse_mode_classifier;

   localparam int NUM_CH  = 2;
   localparam int CNT_W   = 10;
   localparam int THRESH  = 100;
   localparam int MIN_W   = 10;
   localparam int MAX_W   = 400;
   localparam int CONFIRM = 3;
   localparam int LOSS    = 2000;
   localparam int GAP     = 10;

   logic                    clock_50 = 1'b0;
   logic                    reset_n  = 1'b1;
   logic [NUM_CH-1:0]       aux_input = '0;
   logic [NUM_CH-1:0]       mode_out, mode_valid, mode_change, stuck_err;
   logic [NUM_CH*CNT_W-1:0] last_width;

   pulse_mode_classifier #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .THRESH(THRESH), .MIN_WIDTH(MIN_W),
      .MAX_WIDTH(MAX_W), .CONFIRM(CONFIRM), .LOSS_CYCLES(LOSS)
   ) dut (
      .CLOCK_50   (clock_50),
      .RESET_N    (reset_n),
      .AUX_INPUT  (aux_input),
      .MODE_OUT   (mode_out),
      .MODE_VALID (mode_valid),
      .MODE_CHANGE(mode_change),
      .STUCK_ERR  (stuck_err),
      .LAST_WIDTH (last_width)
   );

   // ---------------- clock / reset ----------------
   always #10 clock_50 = ~clock_50;

   int checks   = 0;
   int failures = 0;
   int chg_cnt [NUM_CH];

   // Counts MODE_CHANGE strobes per channel; cleared while reset is held.
   always @(negedge clock_50) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (!reset_n) chg_cnt[c] = 0;
         else if (mode_change[c]) chg_cnt[c] = chg_cnt[c] + 1;
      end
   end

   initial begin
      #10ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic check_ch(input string tag, input int c, input int m, input int v, input int lw, input int chg);
      check($sformatf("%s_ch%0d_mode", tag, c),  int'(mode_out[c]), m);
      check($sformatf("%s_ch%0d_valid", tag, c), int'(mode_valid[c]), v);
      check($sformatf("%s_ch%0d_width", tag, c), int'(last_width[c*CNT_W +: CNT_W]), lw);
      check($sformatf("%s_ch%0d_stuck", tag, c), int'(stuck_err[c]), 0);
      check($sformatf("%s_ch%0d_changes", tag, c), chg_cnt[c], chg);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mode"},   int'(mode_out), 0);
      check({tag, "_valid"},  int'(mode_valid), 0);
      check({tag, "_change"}, int'(mode_change), 0);
      check({tag, "_stuck"},  int'(stuck_err), 0);
      check({tag, "_width"},  int'(last_width), 0);
   endtask

   task automatic apply_reset();
      @(negedge clock_50);
      #1 reset_n = 1'b0;
      aux_input = '0;
      #1 check_all_zero("reset");
      repeat (3) @(negedge clock_50);
      #1 reset_n = 1'b1;
      repeat (5) @(negedge clock_50);
   endtask

   // ---------------- driver ----------------
   // Both channels rise together; each stays high for its own width (0 = no pulse).
   // STUCK_ERR must be low MAX_W+2 negedges after the rise and high one negedge later iff width > MAX_W.
   task automatic drive_round(input int w0, input int w1);
      int len;
      int w [NUM_CH];
      w[0] = w0;
      w[1] = w1;
      len = ((w0 > w1) ? w0 : w1) + 4;
      for (int t = 0; t < len; t++) begin
         @(negedge clock_50);
         for (int c = 0; c < NUM_CH; c++) begin
            if (t == MAX_W + 2)
               check($sformatf("stuck_early_ch%0d_w%0d", c, w[c]), int'(stuck_err[c]), 0);
            if (t == MAX_W + 3)
               check($sformatf("stuck_set_ch%0d_w%0d", c, w[c]), int'(stuck_err[c]), (w[c] > MAX_W) ? 1 : 0);
            aux_input[c] = (t < w[c]);
         end
      end
      aux_input = '0;
      repeat (GAP) @(negedge clock_50);
   endtask

   // ---------------- reference model (pulse level) ----------------
   int m_mode [NUM_CH];
   int m_valid [NUM_CH];
   int m_lw [NUM_CH];
   int m_chg [NUM_CH];
   int hist [NUM_CH][$];

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_mode[c] = 0; m_valid[c] = 0; m_lw[c] = 0; m_chg[c] = 0;
         hist[c].delete();
      end
   endtask

   // Commit when the last CONFIRM accepted pulses (since reset/stuck) all share a class different from the output.
   task automatic model_pulse(input int c, input int w);
      int cls;
      bit same;
      if (w == 0) return;
      if (w > MAX_W) begin
         hist[c].delete();
         return;
      end
      if (w < MIN_W) return;
      cls = (w >= THRESH) ? 1 : 0;
      m_lw[c] = w;
      hist[c].push_back(cls);
      if (hist[c].size() > CONFIRM) void'(hist[c].pop_front());
      if (hist[c].size() == CONFIRM) begin
         same = 1'b1;
         for (int k = 0; k < hist[c].size(); k++)
            if (hist[c][k] != cls) same = 1'b0;
         if (same && (m_valid[c] == 0 || m_mode[c] != cls)) begin
            m_mode[c]  = cls;
            m_valid[c] = 1;
            m_chg[c]++;
         end
      end
   endtask

   function automatic int pick_width(input int cat);
      if (cat == 0) return $urandom_range(1, MIN_W - 1);
      if (cat <= 4) return $urandom_range(MIN_W, THRESH - 1);
      if (cat <= 8) return $urandom_range(THRESH, MAX_W);
      return $urandom_range(MAX_W + 1, MAX_W + 30);
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      bit rst;
      int w0, w1;
      int m0, v0, m1, v1, lw0, lw1, c0, c1;
   } vec_t;

   vec_t tbl[$];

   task automatic add_vec(input bit rst, input int w0, input int w1, input int m0, input int v0,
                          input int m1, input int v1, input int lw0, input int lw1, input int c0, input int c1);
      vec_t v;
      v.rst = rst; v.w0 = w0; v.w1 = w1;
      v.m0 = m0; v.v0 = v0; v.m1 = m1; v.v1 = v1;
      v.lw0 = lw0; v.lw1 = lw1; v.c0 = c0; v.c1 = c1;
      tbl.push_back(v);
   endtask

   initial begin
      int cat [NUM_CH];
      int w0, w1;

      // rst  w0   w1   m0 v0 m1 v1 lw0  lw1  c0 c1
      // Five 150-cycle pulses on ch0, then ch1 held high 500 cycles.
      add_vec(1, 150,   0, 0, 0, 0, 0, 150,   0, 0, 0);
      add_vec(0, 150,   0, 0, 0, 0, 0, 150,   0, 0, 0);
      add_vec(0, 150,   0, 1, 1, 0, 0, 150,   0, 1, 0);
      add_vec(0, 150,   0, 1, 1, 0, 0, 150,   0, 1, 0);
      add_vec(0, 150,   0, 1, 1, 0, 0, 150,   0, 1, 0);
      add_vec(0,   0, 500, 1, 1, 0, 0, 150,   0, 1, 0);
      // 150,150,50,50,50 on ch0; ch1 walks the MIN/THRESH/MAX boundaries.
      add_vec(1, 150,   9, 0, 0, 0, 0, 150,   0, 0, 0);
      add_vec(0, 150,  10, 0, 0, 0, 0, 150,  10, 0, 0);
      add_vec(0,  50,  99, 0, 0, 0, 0,  50,  99, 0, 0);
      add_vec(0,  50, 100, 0, 0, 0, 0,  50, 100, 0, 0);
      add_vec(0,  50, 400, 0, 1, 0, 0,  50, 400, 1, 0);
      // Glitch on ch0; ch1 commits mode 0, goes stuck, then both commit together.
      add_vec(1, 150,  99, 0, 0, 0, 0, 150,  99, 0, 0);
      add_vec(0,   5,  99, 0, 0, 0, 0, 150,  99, 0, 0);
      add_vec(0, 150,  99, 0, 0, 0, 1, 150,  99, 0, 1);
      add_vec(0, 150, 100, 1, 1, 0, 1, 150, 100, 1, 1);
      add_vec(0,   0, 401, 1, 1, 0, 1, 150, 100, 1, 1);
      add_vec(0,  60, 100, 1, 1, 0, 1,  60, 100, 1, 1);
      add_vec(0,  60, 100, 1, 1, 0, 1,  60, 100, 1, 1);
      add_vec(0,  60, 100, 0, 1, 1, 1,  60, 100, 2, 2);
      add_vec(0,  60, 100, 0, 1, 1, 1,  60, 100, 2, 2);
      add_vec(0,  60,   1, 0, 1, 1, 1,  60, 100, 2, 2);

      foreach (tbl[i]) begin
         if (tbl[i].rst) apply_reset();
         drive_round(tbl[i].w0, tbl[i].w1);
         check_ch($sformatf("row%0d", i), 0, tbl[i].m0, tbl[i].v0, tbl[i].lw0, tbl[i].c0);
         check_ch($sformatf("row%0d", i), 1, tbl[i].m1, tbl[i].v1, tbl[i].lw1, tbl[i].c1);
      end

      // Single low cycle between pulses: the next rise lands in the classify cycle.
      apply_reset();
      for (int p = 0; p < 3; p++) begin
         for (int t = 0; t < 151; t++) begin
            @(negedge clock_50);
            aux_input[0] = (t < 150);
         end
      end
      aux_input = '0;
      repeat (20) @(negedge clock_50);
      check_ch("gap1", 0, 1, 1, 150, 1);

      // Reset in the middle of a pulse, then three fresh pulses are needed.
      apply_reset();
      repeat (3) drive_round(150, 150);
      check_ch("pre_rst", 0, 1, 1, 150, 1);
      check_ch("pre_rst", 1, 1, 1, 150, 1);
      for (int t = 0; t < 75; t++) begin
         @(negedge clock_50);
         aux_input = '1;
      end
      #1 reset_n = 1'b0;
      #1 check_all_zero("mid_rst");
      @(negedge clock_50);
      #1 reset_n = 1'b1;
      repeat (75) @(negedge clock_50);
      aux_input = '0;
      repeat (20) @(negedge clock_50);
      check_ch("partial", 0, 0, 0, 0, 0);
      check_ch("partial", 1, 0, 0, 0, 0);
      repeat (2) drive_round(150, 150);
      check_ch("fresh2", 0, 0, 0, 150, 0);
      check_ch("fresh2", 1, 0, 0, 150, 0);
      drive_round(150, 150);
      check_ch("fresh3", 0, 1, 1, 150, 1);
      check_ch("fresh3", 1, 1, 1, 150, 1);

      // Long silence after a commit.
      apply_reset();
      repeat (3) drive_round(150, 0);
      check_ch("loss_pre", 0, 1, 1, 150, 1);
      repeat (LOSS + 100) @(negedge clock_50);
`ifdef PULSE_LOSS_DETECT_EN
      check_ch("loss", 0, 1, 0, 150, 2);
      repeat (2) drive_round(150, 0);
      check_ch("loss_re2", 0, 1, 0, 150, 2);
      drive_round(150, 0);
      check_ch("loss_re3", 0, 1, 1, 150, 3);
`else
      check_ch("loss", 0, 1, 1, 150, 1);
      repeat (3) drive_round(150, 0);
      check_ch("loss_re3", 0, 1, 1, 150, 1);
`endif

      // Randomised rounds against the pulse-level model; categories are sticky so streaks form.
      apply_reset();
      model_reset();
      cat[0] = 5;
      cat[1] = 2;
      for (int r = 0; r < 40; r++) begin
         for (int c = 0; c < NUM_CH; c++)
            if ($urandom_range(0, 4) == 0) cat[c] = $urandom_range(0, 9);
         w0 = pick_width(cat[0]);
         w1 = pick_width(cat[1]);
         model_pulse(0, w0);
         model_pulse(1, w1);
         drive_round(w0, w1);
         for (int c = 0; c < NUM_CH; c++)
            check_ch($sformatf("rnd%0d", r), c, m_mode[c], m_valid[c], m_lw[c], m_chg[c]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
